wb_arbiter: RTL and testbench

//  Two-master to one-slave Wishbone B4 classic arbiter; shares the single memory port

---
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with a bus-timeout watchdog.
// Grant registered one cycle after CYC; slave/return paths are combinational muxes from the grant.
module wb_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;      // 1 = M1 was served last, so M0 wins the next tie
  logic [CW-1:0] tcnt;
  logic          own0;
  logic          own1;
  logic          own_cyc;
  logic          own_stb;
  logic          tmo;

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign tmo     = (TIMEOUT > 0) && own_stb && !s_ack_i && !s_err_i && (tcnt == TLAST);

  // Re-arbitrate whenever nobody holds the bus, including the edge the owner drops CYC.
  always_comb begin
    state_nxt = state;
    if (!own_cyc) begin
      if (m0_cyc_i && m1_cyc_i) state_nxt = ((FIXED_PRIO != 0) || last) ? OWN0 : OWN1;
      else if (m0_cyc_i)        state_nxt = OWN0;
      else if (m1_cyc_i)        state_nxt = OWN1;
      else                      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        if (state_nxt == OWN0)      last <= 1'b0;
        else if (state_nxt == OWN1) last <= 1'b1;
      end
      if ((state_nxt != state) || !own_cyc || s_ack_i || s_err_i || tmo) tcnt <= '0;
      else if ((TIMEOUT > 0) && own_stb)                             tcnt <= tcnt + 1'b1;
    end
  end

  assign gnt_o = state;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~tmo;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~tmo;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & (s_err_i | tmo);
  assign m1_err_o = own1 & (s_err_i | tmo);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: round-robin and fixed-priority instances against a transaction-level model.
module tb_wb_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8, TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [SW-1:0] m0_sel = 0, m1_sel = 0;
  logic [AW-1:0] m0_adr = 0, m1_adr = 0;
  logic [DW-1:0] m0_dat = 0, m1_dat = 0, s_dat = 0;
  logic          s_ack = 0, s_err = 0;

  logic [DW-1:0] o_m0_dat[2], o_m1_dat[2], o_s_dat[2];
  logic [AW-1:0] o_s_adr[2];
  logic [SW-1:0] o_s_sel[2];
  logic [1:0]    o_gnt[2];
  logic          o_m0_ack[2], o_m1_ack[2], o_m0_err[2], o_m1_err[2];
  logic          o_s_cyc[2], o_s_stb[2], o_s_we[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter #(.FIXED_PRIO(g), .TIMEOUT(TO), .AW(AW), .DW(DW)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(o_m0_dat[g]),
      .m0_ack_o(o_m0_ack[g]), .m0_err_o(o_m0_err[g]),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(o_m1_dat[g]),
      .m1_ack_o(o_m1_ack[g]), .m1_err_o(o_m1_err[g]),
      .s_cyc_o(o_s_cyc[g]), .s_stb_o(o_s_stb[g]), .s_we_o(o_s_we[g]), .s_sel_o(o_s_sel[g]),
      .s_adr_o(o_s_adr[g]), .s_dat_o(o_s_dat[g]), .s_dat_i(s_dat),
      .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(o_gnt[g])
    );
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: owner -1/0/1, last served master, count of unanswered strobe cycles.
  int own[2], lst[2], cnt[2];

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin own[p] = -1; lst[p] = 1; cnt[p] = 0; end
  endtask

  function automatic bit owner_cyc(int p);
    return (own[p] == 0) ? m0_cyc : (own[p] == 1) ? m1_cyc : 1'b0;
  endfunction
  function automatic bit owner_stb(int p);
    return (own[p] == 0) ? m0_stb : (own[p] == 1) ? m1_stb : 1'b0;
  endfunction
  function automatic bit timed_out(int p);
    return owner_stb(p) && !s_ack && !s_err && (cnt[p] == TO - 1);
  endfunction

  task automatic check_dut(input int p);
    bit hit;
    hit = timed_out(p);
    chk($sformatf("u%0d.gnt", p), 64'(o_gnt[p]), (own[p] < 0) ? 64'd0 : 64'(1 << own[p]));
    chk($sformatf("u%0d.s_cyc", p), 64'(o_s_cyc[p]), 64'(owner_cyc(p)));
    chk($sformatf("u%0d.s_stb", p), 64'(o_s_stb[p]), 64'(owner_stb(p) && !hit));
    chk($sformatf("u%0d.s_we", p), 64'(o_s_we[p]),
        64'((own[p] == 0) ? m0_we : (own[p] == 1) ? m1_we : 1'b0));
    chk($sformatf("u%0d.s_sel", p), 64'(o_s_sel[p]),
        (own[p] == 0) ? 64'(m0_sel) : (own[p] == 1) ? 64'(m1_sel) : 64'd0);
    chk($sformatf("u%0d.s_adr", p), 64'(o_s_adr[p]),
        (own[p] == 0) ? 64'(m0_adr) : (own[p] == 1) ? 64'(m1_adr) : 64'd0);
    chk($sformatf("u%0d.s_dat", p), 64'(o_s_dat[p]),
        (own[p] == 0) ? 64'(m0_dat) : (own[p] == 1) ? 64'(m1_dat) : 64'd0);
    chk($sformatf("u%0d.m0_dat", p), 64'(o_m0_dat[p]), 64'(s_dat));
    chk($sformatf("u%0d.m1_dat", p), 64'(o_m1_dat[p]), 64'(s_dat));
    chk($sformatf("u%0d.m0_ack", p), 64'(o_m0_ack[p]), 64'(own[p] == 0 && s_ack));
    chk($sformatf("u%0d.m1_ack", p), 64'(o_m1_ack[p]), 64'(own[p] == 1 && s_ack));
    chk($sformatf("u%0d.m0_err", p), 64'(o_m0_err[p]), 64'(own[p] == 0 && (s_err || hit)));
    chk($sformatf("u%0d.m1_err", p), 64'(o_m1_err[p]), 64'(own[p] == 1 && (s_err || hit)));
  endtask

  task automatic model_edge(input int p);
    int nxt;
    bit hit;
    if (!rst_n) begin own[p] = -1; lst[p] = 1; cnt[p] = 0; return; end
    hit = timed_out(p);
    nxt = own[p];
    if (!owner_cyc(p)) begin
      if (m0_cyc && m1_cyc) nxt = (p == 1) ? 0 : 1 - lst[p];
      else if (m0_cyc)      nxt = 0;
      else if (m1_cyc)      nxt = 1;
      else                  nxt = -1;
    end
    if (nxt != own[p] || s_ack || s_err || hit) cnt[p] = 0;
    else if (owner_stb(p))                      cnt[p]++;
    if (nxt >= 0 && nxt != own[p]) lst[p] = nxt;
    own[p] = nxt;
  endtask

  typedef struct {
    logic       c0, s0, c1, s1, ack, err;
    logic [1:0] gnt;
    logic       scyc, sstb, a0, a1, e0, e1;
  } vec_t;
  vec_t tbl[16];
  int   tbl_i = -1;

  // Snapshot of the round-robin instance taken at the last sample point.
  logic [1:0] snap_gnt0, snap_gnt1;
  logic       snap_err0, snap_ack0, snap_stb0;

  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    snap_gnt0 = o_gnt[0]; snap_gnt1 = o_gnt[1];
    snap_err0 = o_m0_err[0]; snap_ack0 = o_m0_ack[0]; snap_stb0 = o_s_stb[0];
    if (tbl_i >= 0) begin
      chk($sformatf("tbl[%0d].gnt", tbl_i), 64'(o_gnt[0]), 64'(tbl[tbl_i].gnt));
      chk($sformatf("tbl[%0d].s_cyc", tbl_i), 64'(o_s_cyc[0]), 64'(tbl[tbl_i].scyc));
      chk($sformatf("tbl[%0d].s_stb", tbl_i), 64'(o_s_stb[0]), 64'(tbl[tbl_i].sstb));
      chk($sformatf("tbl[%0d].acks", tbl_i), 64'({o_m0_ack[0], o_m1_ack[0]}),
          64'({tbl[tbl_i].a0, tbl[tbl_i].a1}));
      chk($sformatf("tbl[%0d].errs", tbl_i), 64'({o_m0_err[0], o_m1_err[0]}),
          64'({tbl[tbl_i].e0, tbl[tbl_i].e1}));
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] in_v, input logic [1:0] g, input logic [5:0] out_v);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack, v.err} = in_v;
    v.gnt = g;
    {v.scyc, v.sstb, v.a0, v.a1, v.e0, v.e1} = out_v;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  int first_err;
  bit stb_at_err;

  initial begin
    //              c0s0c1s1 ak er    gnt    cy st a0 a1 e0 e1
    tbl[0]  = mk(6'b0000_00, 2'b00, 6'b00_0000);
    tbl[1]  = mk(6'b1100_00, 2'b00, 6'b00_0000);
    tbl[2]  = mk(6'b1100_00, 2'b01, 6'b11_0000);
    tbl[3]  = mk(6'b1100_10, 2'b01, 6'b11_1000);
    tbl[4]  = mk(6'b0011_00, 2'b01, 6'b00_0000);
    tbl[5]  = mk(6'b1111_10, 2'b10, 6'b11_0100);
    tbl[6]  = mk(6'b1111_00, 2'b10, 6'b11_0000);
    tbl[7]  = mk(6'b1100_00, 2'b10, 6'b00_0000);
    tbl[8]  = mk(6'b1111_01, 2'b01, 6'b11_0010);
    tbl[9]  = mk(6'b0000_00, 2'b01, 6'b00_0000);
    tbl[10] = mk(6'b1111_00, 2'b00, 6'b00_0000);
    tbl[11] = mk(6'b1111_00, 2'b10, 6'b11_0000);
    tbl[12] = mk(6'b1100_00, 2'b10, 6'b00_0000);
    tbl[13] = mk(6'b1100_00, 2'b01, 6'b11_0000);
    tbl[14] = mk(6'b0000_00, 2'b01, 6'b00_0000);
    tbl[15] = mk(6'b0000_00, 2'b00, 6'b00_0000);

    model_reset();
    #2;
    chk("reset.gnt", 64'({o_gnt[0], o_gnt[1]}), 64'd0);
    chk("reset.s_cyc", 64'({o_s_cyc[0], o_s_cyc[1]}), 64'd0);
    m0_adr = 32'h100; m1_adr = 32'h2000; m0_sel = 4'hf; m1_sel = 4'h3;
    m0_dat = 32'h1111_0000; m1_dat = 32'h2222_0000; s_dat = 32'hcafe_f00d;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err} =
        {tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err};
      tbl_i = i;
      step();
    end
    tbl_i = -1;

    // Watchdog: slave never answers.
    do_reset();
    {m0_cyc, m0_stb, s_ack, s_err} = 4'b1100;
    step();
    first_err = 0; stb_at_err = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (snap_err0 && first_err == 0) begin first_err = k; stb_at_err = snap_stb0; end
    end
    chk("timeout.err_cycle", 64'(first_err), 64'(TO));
    chk("timeout.stb_blocked", 64'(stb_at_err), 64'd0);
    {m0_cyc, m0_stb} = 2'b00;
    step();

    // Ack landing on the terminal-count cycle wins over the watchdog.
    {m0_cyc, m0_stb} = 2'b11;
    step();
    for (int k = 1; k < TO; k++) step();
    s_ack = 1'b1;
    step();
    chk("tmo_ack.ack", 64'(snap_ack0), 64'd1);
    chk("tmo_ack.err", 64'(snap_err0), 64'd0);
    {m0_cyc, m0_stb, s_ack} = 3'b000;
    step();

    // Asynchronous reset while M0 owns with strobe high.
    {m0_cyc, m0_stb} = 2'b11;
    step();
    step();
    chk("arst.pre_gnt", 64'(snap_gnt0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.s_cyc", 64'({o_s_cyc[0], o_s_cyc[1]}), 64'd0);
    chk("arst.s_stb", 64'({o_s_stb[0], o_s_stb[1]}), 64'd0);
    chk("arst.gnt", 64'({o_gnt[0], o_gnt[1]}), 64'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b1111;
    step();
    step();
    chk("arst.tie_rr", 64'(snap_gnt0), 64'd1);
    chk("arst.tie_fixed", 64'(snap_gnt1), 64'd1);
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b0000;
    step();

    // Random traffic against the model; slow-ack phases exercise the watchdog.
    for (int n = 0; n < 4000; n++) begin
      bit slow;
      slow = ((n / 500) % 2) == 1;
      m0_cyc = m0_cyc ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 35);
      m1_cyc = m1_cyc ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 35);
      m0_stb = m0_cyc && ($urandom_range(0, 99) < 80);
      m1_stb = m1_cyc && ($urandom_range(0, 99) < 80);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = SW'($urandom); m1_sel = SW'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = $urandom; m1_dat = $urandom; s_dat = $urandom;
      s_ack = $urandom_range(0, 99) < (slow ? 3 : 30);
      s_err = $urandom_range(0, 99) < (slow ? 1 : 5);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
